// File: rtl/cpu_subsys_dma.sv
// Word-copy DMA initiator for the CPU-subsystem memory bus.
// Copies cfg_len 32-bit words from cfg_src to cfg_dst, one read then one write per word.
module cpu_subsys_dma #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic [29:0]      cfg_src,
    input  logic [29:0]      cfg_dst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err,
    output logic             mem_valid,
    output logic [29:0]      mem_addr,
    output logic             mem_write,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP} state_t;

    state_t           state, state_nxt;
    logic [29:0]      src, dst;
    logic [LEN_W-1:0] cnt;
    logic [31:0]      wbuf;
    logic             abort_pend;
    logic             done_nxt, aborted_nxt, err_nxt;
    logic             start_ok, word_done;

    assign start_ok  = (state == IDLE) && cfg_start && (cfg_src[1:0] == 2'b00) &&
                       (cfg_dst[1:0] == 2'b00) && (cfg_len != '0);
    assign word_done = (state == WR_GAP) && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_src[1:0] != 2'b00 || cfg_dst[1:0] != 2'b00) err_nxt = 1'b1;
                    else if (cfg_len == '0)                             done_nxt = 1'b1;
                    else                                                state_nxt = RD_REQ;
                end
            end
            RD_REQ: if (mem_ready)  state_nxt = RD_GAP;
            // The responder re-acks on the edge valid drops; wait for that to clear.
            RD_GAP: if (!mem_ready) state_nxt = WR_REQ;
            WR_REQ: if (mem_ready)  state_nxt = WR_GAP;
            WR_GAP: begin
                if (!mem_ready) begin
                    if (cnt == LEN_W'(1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else if (abort_pend || cfg_abort) begin
                        aborted_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        state_nxt = RD_REQ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src        <= '0;
            dst        <= '0;
            cnt        <= '0;
            wbuf       <= '0;
            abort_pend <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            err        <= 1'b0;
        end else begin
            done    <= done_nxt;
            aborted <= aborted_nxt;
            err     <= err_nxt;
            if (start_ok) begin
                src <= cfg_src;
                dst <= cfg_dst;
                cnt <= cfg_len;
            end
            if (state == RD_REQ && mem_ready) wbuf <= mem_rdata;
            if (word_done) begin
                cnt <= cnt - LEN_W'(1);
                src <= src + 30'd4;
                dst <= dst + 30'd4;
            end
            if (state_nxt == IDLE)                abort_pend <= 1'b0;
            else if (state != IDLE && cfg_abort)  abort_pend <= 1'b1;
        end
    end

    // Bus fields decode straight from state so reset drops them without a clock.
    assign busy      = (state != IDLE);
    assign mem_valid = (state == RD_REQ) || (state == WR_REQ);
    assign mem_write = (state == WR_REQ);
    assign mem_wstrb = (state == WR_REQ) ? 4'hF : 4'h0;
    assign mem_addr  = (state == RD_REQ) ? src : ((state == WR_REQ) ? dst : 30'd0);
    assign mem_wdata = (state == WR_REQ) ? wbuf : 32'd0;

endmodule

// File: tb/tb_cpu_subsys_dma.sv
// Bench for cpu_subsys_dma: SRAM responder with configurable wait states, a transaction
// queue built from each job's src/dst/len, and directed checks of pulses and timing.
module tb_cpu_subsys_dma;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_start = 1'b0;
    logic [29:0]      cfg_src = '0;
    logic [29:0]      cfg_dst = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_abort = 1'b0;
    logic             busy, done, aborted, err;
    logic             mem_valid, mem_write;
    logic [29:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wstrb;
    logic [31:0]      mem_rdata;
    logic             mem_ready;

    cpu_subsys_dma #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_src(cfg_src),
        .cfg_dst(cfg_dst), .cfg_len(cfg_len), .cfg_abort(cfg_abort), .busy(busy),
        .done(done), .aborted(aborted), .err(err), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- SRAM responder (registered ack, re-acks on valid drop) -----------
    logic [31:0] sram [0:16383];
    int          wait_mode = 0;   // 0: zero wait, 1: random 1..5, 2: fixed 5
    int          waits;
    logic        pl_we = 1'b0;
    logic [29:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    function automatic int idx(input logic [29:0] a);
        return int'(a[15:2]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            waits     <= 0;
        end else begin
            if (pl_we) sram[idx(pl_addr)] <= pl_data;
            if (!mem_valid) begin
                mem_ready <= 1'b0;
                waits     <= (wait_mode == 1) ? int'($urandom_range(5, 1)) :
                             (wait_mode == 2) ? 5 : 0;
            end else if (waits > 0) begin
                waits     <= waits - 1;
                mem_ready <= 1'b0;
            end else begin
                mem_ready <= 1'b1;
                if (mem_write) sram[idx(mem_addr)] <= mem_wdata;
                else           mem_rdata <= sram[idx(mem_addr)];
            end
        end
    end

    task automatic preload(input logic [29:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // ---------------- model: expected bus transactions per job ----------------
    typedef struct {
        logic [29:0] addr;
        logic        wr;
        logic [31:0] data;
    } txn_t;
    txn_t        exp_q[$];
    logic [29:0] rd_log[$];
    int          acc_cnt = 0;

    task automatic plan(input logic [29:0] src, input logic [29:0] dst, input int n);
        for (int i = 0; i < n; i++) begin
            logic [29:0] s, d;
            s = src + 30'(4 * i);
            d = dst + 30'(4 * i);
            exp_q.push_back('{addr: s, wr: 1'b0, data: 32'd0});
            exp_q.push_back('{addr: d, wr: 1'b1, data: sram[idx(s)]});
        end
    endtask

    // ---------------- per-cycle compare process ----------------
    logic        prev_stall = 1'b0;
    logic [29:0] prev_addr = '0;
    logic        prev_write = 1'b0;
    logic [31:0] prev_wdata = '0;
    logic [2:0]  prev_pulse = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_valid) begin
                chk("wstrb", {60'd0, mem_wstrb}, mem_write ? 64'hF : 64'h0);
                chk("addr_align", {62'd0, mem_addr[1:0]}, 64'd0);
            end
            if (mem_valid && mem_ready) begin
                acc_cnt <= acc_cnt + 1;
                if (!mem_write) rd_log.push_back(mem_addr);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_txn: got addr %0h write %0b expected none", mem_addr, mem_write);
                end else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    chk("txn_addr", {34'd0, mem_addr}, {34'd0, t.addr});
                    chk("txn_write", {63'd0, mem_write}, {63'd0, t.wr});
                    if (t.wr) chk("txn_wdata", {32'd0, mem_wdata}, {32'd0, t.data});
                end
            end
            if (prev_stall && mem_valid) begin
                chk("stall_addr", {34'd0, mem_addr}, {34'd0, prev_addr});
                chk("stall_write", {63'd0, mem_write}, {63'd0, prev_write});
                chk("stall_wdata", {32'd0, mem_wdata}, {32'd0, prev_wdata});
            end
            chk("pulse_excl", {63'd0, ($countones({done, aborted, err}) <= 1)}, 64'd1);
            chk("pulse_width", {61'd0, ({done, aborted, err} & prev_pulse)}, 64'd0);
            prev_stall <= mem_valid && !mem_ready;
            prev_addr  <= mem_addr;
            prev_write <= mem_write;
            prev_wdata <= mem_wdata;
            prev_pulse <= {done, aborted, err};
        end else begin
            prev_stall <= 1'b0;
            prev_pulse <= '0;
        end
    end

    // ---------------- job helpers ----------------
    task automatic pulse_start(input logic [29:0] s, input logic [29:0] d, input int len);
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_src = s; cfg_dst = d; cfg_len = LEN_W'(len);
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    // Counts edges after the start edge until done/aborted; optional abort/restart injection.
    task automatic wait_end(input int maxc, input int abort_at, input int restart_at,
                            output int n, output logic d, output logic a, output logic all_busy);
        n = 0; d = 1'b0; a = 1'b0; all_busy = 1'b1;
        while (n < maxc) begin
            n++;
            @(posedge clk); #1;
            cfg_abort = (n == abort_at);
            if (n == restart_at) begin
                cfg_start = 1'b1; cfg_src = 30'h800; cfg_dst = 30'h900; cfg_len = LEN_W'(1);
            end else begin
                cfg_start = 1'b0;
            end
            @(negedge clk);
            if (done || aborted) begin
                d = done; a = aborted;
                break;
            end
            if (!busy) all_busy = 1'b0;
        end
        cfg_abort = 1'b0;
        cfg_start = 1'b0;
        if (!d && !a) begin
            checks++; errors++;
            $display("FAIL timeout: got no completion after %0d cycles expected done or aborted", n);
        end
    endtask

    int   n, acc0;
    logic d, a, ab;

    initial begin
        // reset state
        #13;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_pulses", {61'd0, done, aborted, err}, 64'd0);
        chk("rst_addr", {34'd0, mem_addr}, 64'd0);
        chk("rst_wstrb", {60'd0, mem_wstrb}, 64'd0);
        #15 rst_n = 1'b1;

        preload(30'h100, 32'hAAAA0001);
        preload(30'h104, 32'hBBBB0002);
        preload(30'h108, 32'hCCCC0003);
        for (int i = 0; i < 4; i++) begin
            preload(30'h1000 + 30'(4 * i), 32'h1000_0000 + 32'(i * 32'h111));
            preload(30'h3000 + 30'(4 * i), 32'h3000_0000 + 32'(i));
            preload(30'h4000 + 30'(4 * i), 32'hDEADBEEF);
        end
        preload(30'h3FFFFFFC, 32'h7777_FFFC);
        preload(30'h0, 32'h0000_0F0F);
        preload(30'h600, 32'hDEADBEEF);
        preload(30'h900, 32'hDEADBEEF);

        // basic 3-word copy, zero-wait responder
        plan(30'h100, 30'h200, 3);
        acc0 = acc_cnt;
        pulse_start(30'h100, 30'h200, 3);
        wait_end(100, -1, -1, n, d, a, ab);
        chk("t1_done_cycle", 64'(n), 64'd24);
        chk("t1_done", {63'd0, d}, 64'd1);
        chk("t1_busy_throughout", {63'd0, ab}, 64'd1);
        chk("t1_busy_after", {63'd0, busy}, 64'd0);
        chk("t1_txn_count", 64'(acc_cnt - acc0), 64'd6);
        chk("t1_w0", {32'd0, sram[idx(30'h200)]}, 64'hAAAA0001);
        chk("t1_w1", {32'd0, sram[idx(30'h204)]}, 64'hBBBB0002);
        chk("t1_w2", {32'd0, sram[idx(30'h208)]}, 64'hCCCC0003);
        @(negedge clk);
        chk("t1_done_once", {63'd0, done}, 64'd0);

        // misaligned source -> err, no bus activity
        acc0 = acc_cnt;
        pulse_start(30'h102, 30'h200, 2);
        @(negedge clk);
        chk("err_pulse", {63'd0, err}, 64'd1);
        chk("err_no_done", {63'd0, done}, 64'd0);
        chk("err_valid", {63'd0, mem_valid}, 64'd0);
        chk("err_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        chk("err_no_txn", 64'(acc_cnt - acc0), 64'd0);

        // zero length -> immediate done, never busy
        pulse_start(30'h100, 30'h200, 0);
        @(negedge clk);
        chk("len0_done", {63'd0, done}, 64'd1);
        chk("len0_busy", {63'd0, busy}, 64'd0);
        chk("len0_valid", {63'd0, mem_valid}, 64'd0);
        @(negedge clk);
        chk("len0_done_once", {63'd0, done}, 64'd0);

        // random wait states, stability checked per cycle
        wait_mode = 1;
        plan(30'h1000, 30'h2000, 4);
        pulse_start(30'h1000, 30'h2000, 4);
        wait_end(400, -1, -1, n, d, a, ab);
        chk("wait_done", {63'd0, d}, 64'd1);
        for (int i = 0; i < 4; i++)
            chk("wait_data", {32'd0, sram[idx(30'h2000 + 30'(4 * i))]},
                {32'd0, 32'h1000_0000 + 32'(i * 32'h111)});
        wait_mode = 0;

        // abort during read of word 2 of 4
        plan(30'h3000, 30'h4000, 2);
        pulse_start(30'h3000, 30'h4000, 4);
        wait_end(100, 9, -1, n, d, a, ab);
        chk("abort_pulse", {63'd0, a}, 64'd1);
        chk("abort_no_done", {63'd0, d}, 64'd0);
        chk("abort_cycle", 64'(n), 64'd16);
        chk("abort_w1", {32'd0, sram[idx(30'h4004)]}, 64'h30000001);
        chk("abort_w2_untouched", {32'd0, sram[idx(30'h4008)]}, 64'hDEADBEEF);
        chk("abort_w3_untouched", {32'd0, sram[idx(30'h400C)]}, 64'hDEADBEEF);

        // abort on the last word -> done wins
        plan(30'h3000, 30'h5000, 2);
        pulse_start(30'h3000, 30'h5000, 2);
        wait_end(100, 9, -1, n, d, a, ab);
        chk("abort_last_done", {63'd0, d}, 64'd1);
        chk("abort_last_no_aborted", {63'd0, a}, 64'd0);

        // source wraps past the top of the address space
        rd_log.delete();
        plan(30'h3FFFFFFC, 30'h500, 2);
        pulse_start(30'h3FFFFFFC, 30'h500, 2);
        wait_end(100, -1, -1, n, d, a, ab);
        chk("wrap_done", {63'd0, d}, 64'd1);
        chk("wrap_rd_count", 64'(rd_log.size()), 64'd2);
        if (rd_log.size() == 2) begin
            chk("wrap_rd0", {34'd0, rd_log[0]}, 64'h3FFFFFFC);
            chk("wrap_rd1", {34'd0, rd_log[1]}, 64'h0);
        end
        chk("wrap_w1", {32'd0, sram[idx(30'h504)]}, 64'h00000F0F);

        // reset while stalled in a write request
        wait_mode = 2;
        plan(30'h100, 30'h600, 2);
        pulse_start(30'h100, 30'h600, 2);
        n = 0;
        while (!(mem_valid && mem_write) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached_wr", {63'd0, mem_valid && mem_write}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        exp_q.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        wait_mode = 0;
        chk("rst_mid_no_write", {32'd0, sram[idx(30'h600)]}, 64'hDEADBEEF);

        // fresh copy after reset, with an ignored start while busy
        plan(30'h100, 30'h700, 3);
        acc0 = acc_cnt;
        pulse_start(30'h100, 30'h700, 3);
        wait_end(100, -1, 5, n, d, a, ab);
        chk("restart_done_cycle", 64'(n), 64'd24);
        chk("restart_txn_count", 64'(acc_cnt - acc0), 64'd6);
        chk("restart_w2", {32'd0, sram[idx(30'h708)]}, 64'hCCCC0003);
        repeat (4) @(negedge clk);
        chk("restart_ignored", {32'd0, sram[idx(30'h900)]}, 64'hDEADBEEF);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
